// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store controller and its alignment helper.
//   SZ_*          access size encodings carried on HB
//   FC_*          fault cause codes reported on o_FAULT_CAUSE
//   state_t       controller FSM state encoding
//   BUS_ADDR_MASK strips the region nibble before the address goes onto the bus
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ALIGN   = 2'b01;
    localparam logic [1:0] FC_UNMAP   = 2'b10;
    localparam logic [1:0] FC_TIMEOUT = 2'b11;
    localparam logic [31:0] BUS_ADDR_MASK = 32'h0FFF_FFFF;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_DATA, S_DONE, S_FAULT} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-enable generation, store lane replication and load extract/extend.
//   addr_i   low address bits selecting the lane
//   hb_i     access size (SZ_BYTE/HALF/WORD; 11 gives zero enables)
//   uns_i    zero-extend loads when 1
//   wdata_i  LSB-aligned store data      -> wdata_o lane-replicated store data
//   rdata_i  raw bus word                -> rdata_o aligned, extended load data
//   be_o     byte enables
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [1:0]  hb_i,
    input  logic        uns_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [31:0] sh;
    // aligned halves have addr_i[0]=0, so one byte-granular shift serves both sizes
    assign sh = rdata_i >> {addr_i, 3'b000};
    assign be_o = hb_i == SZ_BYTE ? 4'b0001 << addr_i :
                  hb_i == SZ_HALF ? 4'b0011 << {addr_i[1], 1'b0} :
                  hb_i == SZ_WORD ? 4'b1111 : 4'b0000;
    assign wdata_o = hb_i == SZ_BYTE ? {4{wdata_i[7:0]}} :
                     hb_i == SZ_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    assign rdata_o = hb_i == SZ_BYTE ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
                     hb_i == SZ_HALF ? {{16{~uns_i & sh[15]}}, sh[15:0]} : rdata_i;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: registered load/store controller between the core memory stage and the system bus.
//   Core side: i_WDATA, i_ADDR, i_WE, i_RE, i_HB, i_UNSIGNED in;
//              o_RDATA, o_STALL, o_DONE, o_FAULT, o_FAULT_CAUSE out.
//   Bus side:  o_BUS_WDATA, o_BUS_ADDR, o_BUS_WE, o_BUS_HB, o_BUS_BE, o_BUS_CE, o_BUS_REQ out;
//              i_BUS_RDATA, i_BUS_GNT in.
//   Bus outputs are only non-zero while a request is outstanding.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int N_CE        = 8,
    parameter int REGION_SPAN = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic            i_CLK,
    input  logic            i_RST_N,
    input  logic [31:0]     i_WDATA,
    input  logic [31:0]     i_ADDR,
    input  logic            i_WE,
    input  logic            i_RE,
    input  logic [1:0]      i_HB,
    input  logic            i_UNSIGNED,
    output logic [31:0]     o_RDATA,
    output logic            o_STALL,
    output logic            o_DONE,
    output logic            o_FAULT,
    output logic [1:0]      o_FAULT_CAUSE,
    input  logic [31:0]     i_BUS_RDATA,
    output logic [31:0]     o_BUS_WDATA,
    output logic [31:0]     o_BUS_ADDR,
    output logic            o_BUS_WE,
    output logic [1:0]      o_BUS_HB,
    output logic [3:0]      o_BUS_BE,
    output logic [N_CE-1:0] o_BUS_CE,
    output logic            o_BUS_REQ,
    input  logic            i_BUS_GNT
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam int RS = $clog2(REGION_SPAN);

    state_t          st_q, st_d;
    logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]      hb_q, hb_d, cause_q, cause_d;
    logic            we_q, we_d, uns_q, uns_d;
    logic [N_CE-1:0] ce_q, ce_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [3:0]  idx, be;
    logic        mapped, bad, in_req;
    logic [31:0] wrep, rext;

    assign idx    = i_ADDR[31:28] >> RS;
    assign mapped = 32'(idx) < N_CE;
    assign bad    = (i_HB == SZ_HALF && i_ADDR[0]) || (i_HB == SZ_WORD && i_ADDR[1:0] != 2'b00) ||
                    i_HB == 2'b11 || (i_WE && i_RE);

    lsu_align u_align (
        .addr_i  (addr_q[1:0]),
        .hb_i    (hb_q),
        .uns_i   (uns_q),
        .wdata_i (wdata_q),
        .rdata_i (i_BUS_RDATA),
        .be_o    (be),
        .wdata_o (wrep),
        .rdata_o (rext)
    );

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            st_q    <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            hb_q    <= '0;
            cause_q <= FC_NONE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            ce_q    <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            hb_q    <= hb_d;
            cause_q <= cause_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            ce_q    <= ce_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        hb_d    = hb_q;
        cause_d = cause_q;
        we_d    = we_q;
        uns_d   = uns_q;
        ce_d    = ce_q;
        cnt_d   = cnt_q;
        unique case (st_q)
            S_IDLE: if (i_WE || i_RE) begin
                addr_d  = i_ADDR;
                wdata_d = i_WDATA;
                hb_d    = i_HB;
                we_d    = i_WE;
                uns_d   = i_UNSIGNED;
                ce_d    = mapped ? N_CE'(1) << idx : '0;
                cnt_d   = '0;
                // stores report zero read data, so clear the stale load result here
                rdata_d = '0;
                st_d    = bad || !mapped ? S_FAULT : S_REQ;
                cause_d = bad ? FC_ALIGN : FC_UNMAP;
            end
            S_REQ: begin
                cnt_d = 32'(cnt_q) < TIMEOUT ? cnt_q + CW'(1) : cnt_q;
                // grant is checked first so it wins over a coincident timeout
                if (i_BUS_GNT) begin
                    st_d = we_q ? S_DONE : S_DATA;
                end else if (TIMEOUT > 0 && 32'(cnt_q) == TIMEOUT - 1) begin
                    st_d    = S_FAULT;
                    cause_d = FC_TIMEOUT;
                end
            end
            S_DATA: begin
                rdata_d = rext;
                st_d    = S_DONE;
            end
            S_DONE:  st_d = S_IDLE;
            S_FAULT: st_d = S_IDLE;
            default: st_d = S_IDLE;
        endcase
    end

    assign in_req        = st_q == S_REQ;
    assign o_STALL       = st_q == S_IDLE ? (i_WE | i_RE) : (in_req || st_q == S_DATA);
    assign o_DONE        = st_q == S_DONE;
    assign o_FAULT       = st_q == S_FAULT;
    assign o_FAULT_CAUSE = o_FAULT ? cause_q : FC_NONE;
    assign o_RDATA       = o_DONE ? rdata_q : '0;
    assign o_BUS_REQ     = in_req;
    assign o_BUS_CE      = in_req ? ce_q : '0;
    assign o_BUS_WE      = in_req & we_q;
    assign o_BUS_HB      = in_req ? hb_q : 2'b00;
    assign o_BUS_BE      = in_req ? be : 4'b0000;
    assign o_BUS_WDATA   = in_req ? wrep : '0;
    assign o_BUS_ADDR    = in_req ? (addr_q & BUS_ADDR_MASK) : '0;
endmodule
